// File: rtl/dac_sample_scheduler_if.sv
// Sample-pair stream from the DSP source into dac_sample_scheduler.
// master = source side, slave = scheduler side.
interface dac_sample_scheduler_if #(
  parameter int DATA_WIDTH = 14
);
  logic                  sValid;
  logic                  sReady;
  logic [DATA_WIDTH-1:0] sDataA;
  logic [DATA_WIDTH-1:0] sDataB;

  modport master (output sValid, sDataA, sDataB, input sReady);
  modport slave  (input sValid, sDataA, sDataB, output sReady);
endinterface

// File: rtl/dac_sample_scheduler.sv
// Buffers {A,B} sample pairs and paces them to the AD56x3 driver, one ce strobe every periodEff clocks.
// Optional macro DAC_SCHED_STATS_EN adds a saturating underrunCnt output.
//
// state    | meaning
// ST_IDLE  | outputs at IDLE_CODE, no strobes, FIFO still fills
// ST_PRIME | waiting for PRIME_LEVEL pairs, outputs hold, no strobes
// ST_RUN   | strobing every periodEff clocks, pop per tick
module dac_sample_scheduler #(
  parameter int                    DATA_WIDTH   = 14,
  parameter int                    FIFO_DEPTH   = 16,
  parameter int                    PERIOD_WIDTH = 16,
  parameter int                    MIN_PERIOD   = 120,
  parameter int                    PRIME_LEVEL  = 8,
  parameter int                    UNDERRUN_MAX = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_CODE    = '0,
  localparam int                   AW           = $clog2(FIFO_DEPTH),
  localparam int                   LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  dac_sample_scheduler_if.slave   s_if,
  output logic                    dacCe,
  output logic [DATA_WIDTH-1:0]   dacDataA,
  output logic [DATA_WIDTH-1:0]   dacDataB,
  output logic                    underrun,
  output logic                    running,
  output logic [LVL_W-1:0]        fifoLevel
`ifdef DAC_SCHED_STATS_EN
  ,
  output logic [15:0]             underrunCnt
`endif
);

  localparam int                    UC_W  = $clog2(UNDERRUN_MAX + 1);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    sready_q, sready_d;
  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PERIOD_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [PERIOD_WIDTH-1:0] period_eff;
  logic [UC_W-1:0]         urun_cnt_q, urun_cnt_d;
  logic                    ce_q, ce_d;
  logic                    urun_q, urun_d;
  logic [DATA_WIDTH-1:0]   data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0]   data_b_q, data_b_d;
  logic                    push, pop, tick, fifo_empty;

  always_comb begin
    period_eff = (period < MIN_P) ? MIN_P : period;
    fifo_empty = (level_q == '0);
    tick       = (state_q == ST_RUN) && (tick_cnt_q == '0);
    push       = s_if.sValid && sready_q;
    // The stop tick strobes IDLE_CODE and must leave the FIFO untouched.
    pop        = tick && enable && !fifo_empty;

    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    urun_cnt_d = urun_cnt_q;
    ce_d       = 1'b0;
    urun_d     = 1'b0;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        // Looking at level_d lets the first strobe follow the priming push by one clock.
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (level_d >= LVL_W'(PRIME_LEVEL)) begin
          state_d    = ST_RUN;
          tick_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (tick) begin
          ce_d       = 1'b1;
          tick_cnt_d = period_eff - PERIOD_WIDTH'(1);
          if (!enable) begin
            state_d    = ST_IDLE;
            urun_cnt_d = '0;
          end else if (!fifo_empty) begin
            {data_a_d, data_b_d} = mem_q[rd_ptr_q];
            urun_cnt_d           = '0;
          end else begin
            urun_d = 1'b1;
            if (urun_cnt_q == UC_W'(UNDERRUN_MAX - 1)) begin
              state_d    = ST_PRIME;
              urun_cnt_d = '0;
            end else begin
              urun_cnt_d = urun_cnt_q + UC_W'(1);
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q - PERIOD_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      data_a_d = IDLE_CODE;
      data_b_d = IDLE_CODE;
    end

    sready_d = (level_d != LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sready_q   <= 1'b1;
      tick_cnt_q <= '0;
      urun_cnt_q <= '0;
      ce_q       <= 1'b0;
      urun_q     <= 1'b0;
      data_a_q   <= IDLE_CODE;
      data_b_q   <= IDLE_CODE;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sready_q   <= sready_d;
      tick_cnt_q <= tick_cnt_d;
      urun_cnt_q <= urun_cnt_d;
      ce_q       <= ce_d;
      urun_q     <= urun_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_if.sDataA, s_if.sDataB};
  end

  assign s_if.sReady = sready_q;
  assign dacCe       = ce_q;
  assign dacDataA    = data_a_q;
  assign dacDataB    = data_b_q;
  assign underrun    = urun_q;
  assign running     = (state_q == ST_RUN);
  assign fifoLevel   = level_q;

`ifdef DAC_SCHED_STATS_EN
  logic [15:0] urun_total_q, urun_total_d;

  always_comb begin
    urun_total_d = urun_total_q;
    if (urun_d && (urun_total_q != 16'hFFFF)) urun_total_d = urun_total_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) urun_total_q <= '0;
    else       urun_total_q <= urun_total_d;
  end

  assign underrunCnt = urun_total_q;
`else
  // No underrun total is kept in this build.
`endif

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: stimulus queues expected strobes, a negedge monitor checks them.
module tb_dac_sample_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic        dacCe;
  logic [13:0] dacDataA;
  logic [13:0] dacDataB;
  logic        underrun;
  logic        running;
  logic [4:0]  fifoLevel;
`ifdef DAC_SCHED_STATS_EN
  logic [15:0] underrunCnt;
`endif

  dac_sample_scheduler_if #(.DATA_WIDTH(14)) s_if ();

  dac_sample_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .period    (period),
    .s_if      (s_if),
    .dacCe     (dacCe),
    .dacDataA  (dacDataA),
    .dacDataB  (dacDataB),
    .underrun  (underrun),
    .running   (running),
    .fifoLevel (fifoLevel)
`ifdef DAC_SCHED_STATS_EN
    ,
    .underrunCnt (underrunCnt)
`endif
  );

  typedef struct {
    logic [13:0] a;
    logic [13:0] b;
    logic        ur;
    int          gap;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   last_ce = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the queue in data, underrun flag and timing.
  always @(negedge clk) begin
    if (!reset && dacCe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got A=%0h B=%0h ur=%0b at cycle %0d, expected no strobe",
                 dacDataA, dacDataB, underrun, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ((dacDataA !== mon_e.a) || (dacDataB !== mon_e.b) || (underrun !== mon_e.ur) ||
            (mon_e.gap != 0 && (cyc - last_ce) != mon_e.gap) ||
            (mon_e.at >= 0 && cyc != mon_e.at)) begin
          errors++;
          $display("FAIL strobe: got A=%0h B=%0h ur=%0b gap=%0d cyc=%0d, expected A=%0h B=%0h ur=%0b gap=%0d at=%0d",
                   dacDataA, dacDataB, underrun, cyc - last_ce, cyc,
                   mon_e.a, mon_e.b, mon_e.ur, mon_e.gap, mon_e.at);
        end
      end
      last_ce = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_strobe(input int a, input int b, input logic ur, input int gap, input int at);
    exp_t e;
    e.a   = 14'(a);
    e.b   = 14'(b);
    e.ur  = ur;
    e.gap = gap;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push_pair(input int a, input int b, output int acc);
    int n = 0;
    s_if.sValid = 1'b1;
    s_if.sDataA = 14'(a);
    s_if.sDataB = 14'(b);
    while (!s_if.sReady && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (!s_if.sReady) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: sReady stayed %0b, expected 1", s_if.sReady);
    end
    @(negedge clk); #1;
    acc = cyc;
    s_if.sValid = 1'b0;
  endtask

  task automatic wait_qsize(input int n, input int limit, input string name);
    int k = 0;
    while (exp_q.size() > n && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (exp_q.size() > n) begin
      errors++;
      $display("FAIL %s_timeout: %0d strobes outstanding, expected %0d", name, exp_q.size(), n);
    end
  endtask

  initial begin
    int acc;
    int m;
    reset       = 1'b1;
    enable      = 1'b0;
    period      = 16'd200;
    s_if.sValid = 1'b0;
    s_if.sDataA = '0;
    s_if.sDataB = '0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;

    chk("rst_dacCe",    32'(dacCe),       0);
    chk("rst_dacDataA", 32'(dacDataA),    0);
    chk("rst_dacDataB", 32'(dacDataB),    0);
    chk("rst_underrun", 32'(underrun),    0);
    chk("rst_running",  32'(running),     0);
    chk("rst_level",    32'(fifoLevel),   0);
    chk("rst_sReady",   32'(s_if.sReady), 1);

    // Prime with 8 pairs at period 200, then starve into 4 underruns.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push_pair(32'h100 + i, 32'h200 + i, acc);
    for (int i = 0; i < 8; i++)
      expect_strobe(32'h100 + i, 32'h200 + i, 1'b0, (i == 0) ? 0 : 200, (i == 0) ? acc + 1 : -1);
    for (int i = 0; i < 4; i++) expect_strobe(32'h107, 32'h207, 1'b1, 200, -1);
    wait_qsize(0, 3000, "starve");
    chk("starve_running_now", 32'(running), 0);
    repeat (250) @(negedge clk);
    #1;
    chk("starve_running_later", 32'(running),  0);
    chk("starve_underrun_low",  32'(underrun), 0);
`ifdef DAC_SCHED_STATS_EN
    chk("stats_count", 32'(underrunCnt), 4);
`endif

    // Period below the floor, then a mid-run change to 300, then drop enable.
    period = 16'd10;
    for (int i = 0; i < 8; i++) push_pair(32'h300 + i, 32'h400 + i, acc);
    for (int i = 0; i < 8; i++)
      expect_strobe(32'h300 + i, 32'h400 + i, 1'b0,
                    (i == 0) ? 0 : ((i <= 3) ? 120 : 300), (i == 0) ? acc + 1 : -1);
    push_pair(32'h308, 32'h408, acc);
    push_pair(32'h309, 32'h409, acc);
    wait_qsize(5, 600, "min_period");
    period = 16'd300;
    wait_qsize(0, 2000, "period_change");
    enable = 1'b0;
    expect_strobe(0, 0, 1'b0, 300, -1);
    wait_qsize(0, 400, "stop");
    chk("stop_running", 32'(running),   0);
    chk("stop_level",   32'(fifoLevel), 2);
    repeat (320) @(negedge clk);
    #1;
    chk("idle_level", 32'(fifoLevel), 2);

    // Fill to full while idle; pushes beyond full must be refused.
    period = 16'd0;
    for (int i = 0; i < 14; i++) push_pair(32'h500 + i, 32'h600 + i, acc);
    chk("full_sReady", 32'(s_if.sReady), 0);
    chk("full_level",  32'(fifoLevel),   16);
    s_if.sValid = 1'b1;
    s_if.sDataA = 14'h3FFF;
    s_if.sDataB = 14'h3FFF;
    repeat (3) @(negedge clk);
    #1;
    s_if.sValid = 1'b0;
    chk("full_hold_level", 32'(fifoLevel), 16);

    m = cyc;
    enable = 1'b1;
    expect_strobe(32'h308, 32'h408, 1'b0, 0, m + 3);
    expect_strobe(32'h309, 32'h409, 1'b0, 120, -1);
    for (int i = 0; i < 14; i++) expect_strobe(32'h500 + i, 32'h600 + i, 1'b0, 120, -1);
    wait_qsize(15, 50, "full_first");
    chk("full_pop_sReady", 32'(s_if.sReady), 1);
    chk("full_pop_level",  32'(fifoLevel),   15);

    // Reset in the middle of a run with 5 pairs still buffered.
    wait_qsize(5, 2000, "pre_reset");
    chk("pre_reset_level", 32'(fifoLevel), 5);
    repeat (30) @(negedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    chk("in_reset_level",   32'(fifoLevel), 0);
    chk("in_reset_running", 32'(running),   0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_dacCe",    32'(dacCe),       0);
    chk("post_rst_dacDataA", 32'(dacDataA),    0);
    chk("post_rst_dacDataB", 32'(dacDataB),    0);
    chk("post_rst_underrun", 32'(underrun),    0);
    chk("post_rst_running",  32'(running),     0);
    chk("post_rst_level",    32'(fifoLevel),   0);
    chk("post_rst_sReady",   32'(s_if.sReady), 1);
`ifdef DAC_SCHED_STATS_EN
    chk("post_rst_stats", 32'(underrunCnt), 0);
`endif
    repeat (200) @(negedge clk);
    #1;
    chk("quiet_level", 32'(fifoLevel), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
